// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port between the instruction-refill and
// data refill/write-back controllers. Round-robin on ties, one transaction at a time.
// Latency: request-to-ack is 2 edges plus the memory wait cycles. Requesters stall while req is pending.
// Ports: i_* instruction side (read only), d_* data side (read or write-back),
//        mem_* memory side (req held until mem_ack), err sticky protocol error.
// All outputs are registered. No input reaches an output combinationally.
module mem_arbiter #(
   parameter int ADDR_BITS = 32,
   parameter int LINE_BITS = 128
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 i_req,
   input  logic [ADDR_BITS-1:0] i_addr,
   output logic                 i_ack,
   output logic [LINE_BITS-1:0] i_rdata,
   input  logic                 d_req,
   input  logic                 d_we,
   input  logic [ADDR_BITS-1:0] d_addr,
   input  logic [LINE_BITS-1:0] d_wdata,
   output logic                 d_ack,
   output logic [LINE_BITS-1:0] d_rdata,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic [LINE_BITS-1:0] mem_wdata,
   input  logic [LINE_BITS-1:0] mem_rdata,
   input  logic                 mem_ack,
   output logic                 err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 w_grant;
   logic                 w_pick_d;
   logic                 w_drop;
   logic                 w_spurious;

   logic                 r_owner_d;   // 1 = data side owns the current transaction
   logic                 r_last_d;    // 1 = last grant went to data, 0 = instruction
   logic                 r_mem_req;
   logic                 r_mem_we;
   logic [ADDR_BITS-1:0] r_mem_addr;
   logic [LINE_BITS-1:0] r_mem_wdata;
   logic [LINE_BITS-1:0] r_buf;
   logic                 r_i_ack;
   logic                 r_d_ack;
   logic                 r_err;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      w_pick_d    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_req || d_req) begin
               w_grant = 1'b1;
               // On a tie the side that did not win last time goes next.
               w_pick_d    = (i_req && d_req) ? !r_last_d : d_req;
               w_state_nxt = S_BUSY;
            end
         end
         S_BUSY: begin
            if (mem_ack) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            // Requests are not looked at here: the owner is dropping req this cycle.
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Owner letting go of req before its ack, and memory acking when nothing is outstanding.
   assign w_drop     = (r_state == S_BUSY) && (r_owner_d ? !d_req : !i_req);
   assign w_spurious = mem_ack && (r_state != S_BUSY);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_owner_d   <= 1'b0;
         r_last_d    <= 1'b0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_buf       <= '0;
         r_i_ack     <= 1'b0;
         r_d_ack     <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_i_ack <= 1'b0;
         r_d_ack <= 1'b0;
         if (w_grant) begin
            r_owner_d   <= w_pick_d;
            r_last_d    <= w_pick_d;
            r_mem_req   <= 1'b1;
            r_mem_we    <= w_pick_d & d_we;
            r_mem_addr  <= w_pick_d ? d_addr : i_addr;
            r_mem_wdata <= w_pick_d ? d_wdata : '0;
         end
         if ((r_state == S_BUSY) && mem_ack) begin
            r_mem_req <= 1'b0;
            // Write-backs leave the returned-line buffer untouched.
            if (!r_mem_we) begin
               r_buf <= mem_rdata;
            end
            r_i_ack <= !r_owner_d;
            r_d_ack <= r_owner_d;
         end
         if (w_spurious || w_drop) begin
            r_err <= 1'b1;
         end
      end
   end

   assign i_ack     = r_i_ack;
   assign d_ack     = r_d_ack;
   assign i_rdata   = r_buf;
   assign d_rdata   = r_buf;
   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign err       = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: random requesters and a random-latency memory against a
// transaction-level timing model, plus directed error and reset scenarios.
module tb_mem_arbiter;
   localparam int AB = 32;
   localparam int LB = 128;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          i_req = 1'b0;
   logic [AB-1:0] i_addr = '0;
   logic          i_ack;
   logic [LB-1:0] i_rdata;
   logic          d_req = 1'b0;
   logic          d_we = 1'b0;
   logic [AB-1:0] d_addr = '0;
   logic [LB-1:0] d_wdata = '0;
   logic          d_ack;
   logic [LB-1:0] d_rdata;
   logic          mem_req;
   logic          mem_we;
   logic [AB-1:0] mem_addr;
   logic [LB-1:0] mem_wdata;
   logic [LB-1:0] mem_rdata = '0;
   logic          mem_ack = 1'b0;
   logic          err;

   always #5 clock = ~clock;

   mem_arbiter #(.ADDR_BITS(AB), .LINE_BITS(LB)) dut (
      .clock(clock), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [LB-1:0] got, input logic [LB-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model state: one outstanding transaction described by its grant
   // edge g and memory wait w. Relative to g: mem_req high in cycles g..g+w,
   // owner ack in cycle g+w+1, idle in g+w+2, next grant possible at edge g+w+3.
   bit            last_d = 1'b0;
   logic [LB-1:0] exp_buf = '0;

   task automatic run_random(input int ncyc, input bit zw, output int n_iack);
      bit            act;
      bit            own_d;
      bit            twe;
      bit            drop_i;
      bit            drop_d;
      bit            drained;
      int            g;
      int            w;
      int            off;
      logic [AB-1:0] taddr;
      logic [LB-1:0] twd;
      logic [LB-1:0] trd;
      bit            e_req;
      bit            e_ia;
      bit            e_da;
      act = 0; own_d = 0; twe = 0; g = 0; w = 0; off = 0;
      taddr = '0; twd = '0; trd = '0; n_iack = 0; drained = 0;
      for (int c = 0; c < ncyc + 300; c++) begin
         off   = c - g;
         e_req = act && (off >= 0) && (off <= w);
         e_ia  = act && (off == w + 1) && !own_d;
         e_da  = act && (off == w + 1) && own_d;
         check_eq("mem_req", LB'(mem_req), LB'(e_req));
         check_eq("i_ack", LB'(i_ack), LB'(e_ia));
         check_eq("d_ack", LB'(d_ack), LB'(e_da));
         check_eq("err_clear", LB'(err), LB'(1'b0));
         if (c < ncyc && i_ack === 1'b1) n_iack++;
         if (e_req) begin
            check_eq("mem_addr", LB'(mem_addr), LB'(taddr));
            check_eq("mem_we", LB'(mem_we), LB'(twe));
            check_eq("mem_wdata", mem_wdata, twd);
         end
         if (act && off == w + 1) begin
            if (!twe) exp_buf = trd;
            check_eq("i_rdata", i_rdata, exp_buf);
            check_eq("d_rdata", d_rdata, exp_buf);
         end
         if (act && off == w + 2) act = 0;
         if (c >= ncyc && !act && !i_req && !d_req) begin
            drained = 1;
            break;
         end
         // Requesters: the owner drops req in its ack cycle; otherwise raise at random.
         drop_i = act && (off == w + 1) && !own_d;
         drop_d = act && (off == w + 1) && own_d;
         if (drop_i) i_req = 1'b0;
         if (drop_d) d_req = 1'b0;
         if (c < ncyc) begin
            if (!i_req && !drop_i && (zw || $urandom_range(0, 3) == 0)) begin
               i_req  = 1'b1;
               i_addr = $urandom;
            end
            if (!zw && !d_req && !drop_d && $urandom_range(0, 3) == 0) begin
               d_req   = 1'b1;
               d_we    = 1'($urandom_range(0, 1));
               d_addr  = $urandom;
               d_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
         end
         mem_ack   = act && (off == w);
         mem_rdata = mem_ack ? trd : {$urandom, $urandom, $urandom, $urandom};
         if (!act && (i_req || d_req)) begin
            own_d  = (i_req && d_req) ? !last_d : d_req;
            last_d = own_d;
            g      = c + 1;
            w      = zw ? 0 : int'($urandom_range(0, 4));
            twe    = own_d ? d_we : 1'b0;
            taddr  = own_d ? d_addr : i_addr;
            twd    = own_d ? d_wdata : '0;
            trd    = {$urandom, $urandom, $urandom, $urandom};
            act    = 1;
         end
         @(negedge clock);
      end
      mem_ack = 1'b0;
      check_eq("drain_done", LB'(drained), LB'(1'b1));
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_mem_req"}, LB'(mem_req), '0);
      check_eq({tag, "_mem_we"}, LB'(mem_we), '0);
      check_eq({tag, "_mem_addr"}, LB'(mem_addr), '0);
      check_eq({tag, "_mem_wdata"}, mem_wdata, '0);
      check_eq({tag, "_i_ack"}, LB'(i_ack), '0);
      check_eq({tag, "_d_ack"}, LB'(d_ack), '0);
      check_eq({tag, "_i_rdata"}, i_rdata, '0);
      check_eq({tag, "_d_rdata"}, d_rdata, '0);
      check_eq({tag, "_err"}, LB'(err), '0);
   endtask

   initial begin
      int            n_iack;
      bit            seen;
      logic [LB-1:0] line;

      // Reset state, during and just after reset.
      repeat (3) @(negedge clock);
      check_reset_outputs("rst");
      reset = 1'b1;
      @(negedge clock);
      check_reset_outputs("rst_rel");

      // Random traffic; the very first cycle is a tie with a data read at 0x100,
      // which the model expects to go to data because last grant resets to instruction.
      last_d  = 1'b0;
      exp_buf = '0;
      i_req   = 1'b1; i_addr = 32'h0000_0040;
      d_req   = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0100; d_wdata = '0;
      run_random(600, 1'b0, n_iack);

      // Zero-wait memory with a continuously requesting instruction side.
      i_req  = 1'b1;
      i_addr = $urandom;
      run_random(30, 1'b1, n_iack);
      check_eq("zero_wait_10_in_30", LB'(n_iack), LB'(10));

      // Spurious mem_ack while idle sets the sticky error and nothing else.
      @(negedge clock);
      mem_ack = 1'b1;
      @(negedge clock);
      mem_ack = 1'b0;
      check_eq("spur_err", LB'(err), LB'(1'b1));
      check_eq("spur_mem_req", LB'(mem_req), '0);
      check_eq("spur_i_ack", LB'(i_ack), '0);
      check_eq("spur_d_ack", LB'(d_ack), '0);
      repeat (3) @(negedge clock);
      check_eq("spur_err_sticky", LB'(err), LB'(1'b1));

      // Reset in the middle of a transaction with both requests held through it.
      i_req = 1'b1; i_addr = 32'h0000_0500;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300;
      seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clock);
         seen = (mem_req === 1'b1);
      end
      check_eq("rst_setup_busy", LB'(seen), LB'(1'b1));
      #2 reset = 1'b0;
      #1;
      check_eq("midrst_mem_req", LB'(mem_req), '0);
      check_eq("midrst_err", LB'(err), '0);
      check_eq("midrst_i_ack", LB'(i_ack), '0);
      check_eq("midrst_d_ack", LB'(d_ack), '0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check_eq("regrant_mem_req", LB'(mem_req), LB'(1'b1));
      check_eq("regrant_addr", LB'(mem_addr), LB'(32'h0000_0300));
      check_eq("regrant_we", LB'(mem_we), '0);
      line      = {$urandom, $urandom, $urandom, $urandom};
      mem_ack   = 1'b1;
      mem_rdata = line;
      @(negedge clock);
      mem_ack = 1'b0;
      check_eq("regrant_d_ack", LB'(d_ack), LB'(1'b1));
      check_eq("regrant_i_ack", LB'(i_ack), '0);
      check_eq("regrant_rdata", d_rdata, line);
      check_eq("regrant_req_low", LB'(mem_req), '0);
      d_req = 1'b0;
      i_req = 1'b0;
      @(negedge clock);
      check_eq("regrant_ack_once", LB'(d_ack), '0);
      repeat (2) @(negedge clock);

      // Owner dropping req while its transaction is in flight: error, but still completes.
      i_req  = 1'b1;
      i_addr = 32'h0000_0040;
      @(negedge clock);
      check_eq("drop_mem_req", LB'(mem_req), LB'(1'b1));
      check_eq("drop_addr", LB'(mem_addr), LB'(32'h0000_0040));
      i_req = 1'b0;
      @(negedge clock);
      check_eq("drop_err", LB'(err), LB'(1'b1));
      line      = {32'hDEAD_0000, $urandom, $urandom, 32'h0000_BEEF};
      mem_ack   = 1'b1;
      mem_rdata = line;
      @(negedge clock);
      mem_ack = 1'b0;
      check_eq("drop_i_ack", LB'(i_ack), LB'(1'b1));
      check_eq("drop_i_rdata", i_rdata, line);
      check_eq("drop_d_ack", LB'(d_ack), '0);
      @(negedge clock);
      check_eq("drop_i_ack_once", LB'(i_ack), '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
